conv_encoder_punct: RTL
=======================

Name: conv_encoder_punct

Overview:
- Transmit-side K=7 convolutional encoder for the 802.11a bit path, with tail insertion and rate-1/2, 2/3 and 3/4 puncturing.
- Pulls serial data bits through a Ready handshake and emits one coded bit per Valid cycle.
- At rate 1/2, its output stream for Length data bits is the input stream the Viterbi decoder expects for Length+6 bit pairs.

Parameters:
- FRAME, 512, maximum data bits per frame.
- LEN_W, 9, width of Length.
- TAIL, 6, number of zero tail bits appended (K-1).

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, asynchronous, active-low reset.
- Start, input, 1, level-sensitive frame enable. Low forces idle.
- Length, input, LEN_W, data bits in the frame. Sampled in IDLE on the first cycle Start is high.
- Rate, input, 2, rate code: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = treated as 1/2. Sampled with Length.
- x, input, 1, data bit. Consumed on the rising edge of any cycle in which Ready=1.
- Ready, output, 1, combinational request for a data bit.
- Out, output, 1, registered coded bit.
- Valid, output, 1, registered. Out is meaningful only when Valid=1.
- Done, output, 1, registered. High once the frame is fully emitted; held until Start goes low.

Behaviour:
- Reset low (async): state IDLE, shift register 0, bit counter 0, punct phase 0, Out=0, Valid=0, Done=0, Ready=0.
- Start low (sync, any state): the same clearing as reset. This aborts a frame mid-way; no partial flush.
- Code, with d_k = input bit k steps earlier:
  - A (g0=133o) = b^d2^d3^d5^d6.
  - B (g1=171o) = b^d1^d2^d3^d6.
  - Emit order is A then B.
- Input sequence: N = Length + TAIL bits. Bits 0..Length-1 come from x; the remaining TAIL bits are 0.
- Puncturing, by phase p, which cycles per input bit and resets at frame start:
  - 1/2: keep A,B always.
  - 2/3: p in 0..1. p0 keep A,B; p1 keep A.
  - 3/4: p in 0..2. p0 keep A,B; p1 keep A; p2 keep B.
- States: IDLE, FETCH, EMIT2, DONE.
- IDLE:
  - On Start=1, latch Length and Rate.
  - Clear the counter and phase.
  - Next state FETCH.
- FETCH:
  - Ready = (bit_cnt < Length_latched).
  - b = x if Ready, else 0.
  - At the edge: compute A,B; shift b into the register; bit_cnt++; advance p.
  - Out <= first kept bit; Valid <= 1. Hold the second kept bit if there is one.
  - Next state is EMIT2 if a second bit is kept. Otherwise FETCH, or DONE if bit_cnt reaches N.
- EMIT2:
  - Ready=0.
  - Out <= held B; Valid <= 1.
  - Next state FETCH, or DONE if bit_cnt == N.
- DONE:
  - Valid <= 0, Done <= 1, Ready=0.
  - Stays until Start low. A new frame requires Start low for at least 1 cycle.
- Latency: a bit consumed at the edge of FETCH appears on Out in the next cycle.
- Valid stays continuously high from the cycle after the first FETCH through the last coded bit.
- Coded bit counts:
  - 1/2: 2N.
  - 2/3: N + ceil(N/2).
  - 3/4: 4*floor(N/3) + (2, 3) for N mod 3 = (1, 2), or +0 for mod 0.
- Length=0: only the 6 tail bits are encoded, giving all-zero output.
- Length and Rate changes mid-frame are ignored.
- bit_cnt is LEN_W+1 bits wide, with no wrap for N up to 517.

Decomposition:
- Package conv_pkg holds:
  - polynomial constants G0=7'o133 and G1=7'o171;
  - TAIL;
  - rate code constants;
  - state enum (IDLE, FETCH, EMIT2, DONE);
  - a puncture-keep function (rate, phase) returning {keepA, keepB}.
- Sub-module conv_core:
  - 6-bit shift register plus A/B combinational outputs;
  - inputs: shift enable, bit, clear.
- Top level holds the FSM, counters and puncturing.

Test Plan:
- Impulse, rate 1/2: Length=1, x=1 on the single Ready.
  - Exactly 1 Ready pulse.
  - 14 Valid bits = 11 01 11 11 00 10 11.
  - Then Done=1, Valid=0.
- Rate 2/3: Length=1, x=1.
  - 11 Valid bits = 1 1 0 1 1 1 0 0 1 1 1.
  - Ready/Valid pattern FETCH,EMIT2,FETCH,... checked cycle by cycle.
- Rate 3/4: Length=1, x=1.
  - 10 Valid bits = 1 1 0 1 1 1 0 0 1 1.
- Rate 11 and Length=0:
  - No Ready.
  - 12 zero bits at rate 1/2, then Done.
- Abort: Length=100 at rate 1/2; drop Start after 20 Valid bits.
  - Next cycle: Valid=0, Ready=0, Done=0.
  - A new frame with Length=1, x=1 reproduces the impulse exactly.
  - Repeat the same check with Reset pulsed low asynchronously mid-cycle.
- Loopback: 512-bit random Length=506 frame at rate 1/2 fed to the Viterbi decoder (Length field 512).
  - Decoded first 506 bits equal the source.
  - Final 6 decoded bits are 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the K=7 convolutional encoder with puncturing.
// Holds frame sizing, generator polynomials, rate codes, the FSM state
// type and the puncture-keep helpers used by the top level.
package conv_pkg;

    localparam int unsigned FRAME = 512;
    localparam int unsigned LEN_W = $clog2(FRAME);
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned K     = 7;
    localparam int unsigned SR_W  = K - 1;
    localparam int unsigned TAIL  = K - 1;
    localparam int unsigned PH_W  = 2;

    // Generator polynomials; MSB taps the current bit, LSB the oldest.
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic keep_a;
        logic keep_b;
    } keep_t;

    // Which of the A/B code bits survive for a given rate and phase.
    function automatic keep_t punct_keep(input logic [1:0] rate,
                                         input logic [PH_W-1:0] phase);
        keep_t k;
        k.keep_a = 1'b1;
        k.keep_b = 1'b1;
        case (rate)
            RATE_2_3: begin
                if (phase != PH_W'(0)) begin
                    k.keep_b = 1'b0;
                end
            end
            RATE_3_4: begin
                case (phase)
                    PH_W'(0): begin
                        k.keep_a = 1'b1;
                        k.keep_b = 1'b1;
                    end
                    PH_W'(1): begin
                        k.keep_a = 1'b1;
                        k.keep_b = 1'b0;
                    end
                    default: begin
                        k.keep_a = 1'b0;
                        k.keep_b = 1'b1;
                    end
                endcase
            end
            default: begin
                k.keep_a = 1'b1;
                k.keep_b = 1'b1;
            end
        endcase
        return k;
    endfunction

    // Phase advance per input bit; period 1, 2 or 3 depending on rate.
    function automatic logic [PH_W-1:0] phase_next(input logic [1:0] rate,
                                                   input logic [PH_W-1:0] phase);
        logic [PH_W-1:0] p;
        p = PH_W'(0);
        case (rate)
            RATE_2_3: p = (phase == PH_W'(0)) ? PH_W'(1) : PH_W'(0);
            RATE_3_4: p = (phase >= PH_W'(2)) ? PH_W'(0) : phase + PH_W'(1);
            default:  p = PH_W'(0);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/conv_core.sv
// K=7 convolutional code core: 6-bit history register plus the two
// combinational code outputs for the bit currently presented.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous clear of the history register
//   shift        shift din into the history at the clock edge
//   din          current input bit
//   code_a_c     G0 (133o) code bit for din + history
//   code_b_c     G1 (171o) code bit for din + history
module conv_core
    import conv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift,
    input  logic din,
    output logic code_a_c,
    output logic code_b_c
);

    // sr[SR_W-1] is the most recent past bit (d1), sr[0] the oldest (d6).
    logic [SR_W-1:0] sr;
    logic [K-1:0]    taps;

    assign taps     = {din, sr};
    assign code_a_c = ^(taps & G0);
    assign code_b_c = ^(taps & G1);

    // History register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (shift) begin
            sr <= {din, sr[SR_W-1:1]};
        end
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// Transmit-side K=7 convolutional encoder with zero-tail insertion and
// rate 1/2, 2/3, 3/4 puncturing. Pulls Length data bits through Ready,
// appends TAIL zero bits, and emits one coded bit per Valid cycle.
// Ports:
//   Clk     rising-edge clock
//   Reset   async active-low reset
//   Start   level frame enable; low aborts and forces idle
//   Length  data bits in the frame, latched at frame start
//   Rate    rate code (00 1/2, 01 2/3, 10 3/4, 11 as 1/2), latched with Length
//   x       data bit, consumed on any edge with Ready high
//   Ready   combinational request for a data bit
//   Out     registered coded bit
//   Valid   registered qualifier for Out
//   Done    registered frame-complete flag, held until Start drops
module conv_encoder_punct
    import conv_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [LEN_W-1:0] Length,
    input  logic [1:0]       Rate,
    input  logic             x,
    output logic             Ready,
    output logic             Out,
    output logic             Valid,
    output logic             Done
);

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [1:0]       rate_q, rate_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic             hold, hold_n;
    logic             out_n, valid_n, done_n;

    logic [CNT_W-1:0] n_total;
    logic             din;
    logic             shift_en;
    logic             core_clear;
    logic             code_a, code_b;
    keep_t            keep;

    // Total bits pushed through the coder: data plus zero tail.
    assign n_total = CNT_W'(len_q) + CNT_W'(TAIL);

    // Data bits are requested only while the data portion is running;
    // during the tail the coder is fed zeros.
    assign Ready      = Start && (state == FETCH) && (cnt < CNT_W'(len_q));
    assign din        = Ready & x;
    assign shift_en   = Start && (state == FETCH);
    assign core_clear = !Start || (state == IDLE);
    assign keep       = punct_keep(rate_q, phase);

    conv_core u_core (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (core_clear),
        .shift    (shift_en),
        .din      (din),
        .code_a_c (code_a),
        .code_b_c (code_b)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        len_n   = len_q;
        rate_n  = rate_q;
        cnt_n   = cnt;
        phase_n = phase;
        hold_n  = hold;
        out_n   = Out;
        valid_n = 1'b0;
        done_n  = 1'b0;

        if (!Start) begin
            state_n = IDLE;
            cnt_n   = '0;
            phase_n = '0;
            hold_n  = 1'b0;
            out_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    len_n   = Length;
                    rate_n  = (Rate == 2'b11) ? RATE_1_2 : Rate;
                    cnt_n   = '0;
                    phase_n = '0;
                    state_n = FETCH;
                end
                FETCH: begin
                    cnt_n   = cnt + CNT_W'(1);
                    phase_n = phase_next(rate_q, phase);
                    valid_n = 1'b1;
                    // First kept bit goes out now; B is parked for EMIT2.
                    out_n   = keep.keep_a ? code_a : code_b;
                    hold_n  = code_b;
                    if (keep.keep_a && keep.keep_b) begin
                        state_n = EMIT2;
                    end else if (cnt_n == n_total) begin
                        state_n = DONE;
                    end else begin
                        state_n = FETCH;
                    end
                end
                EMIT2: begin
                    out_n   = hold;
                    valid_n = 1'b1;
                    state_n = (cnt == n_total) ? DONE : FETCH;
                end
                DONE: begin
                    done_n  = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            len_q  <= '0;
            rate_q <= RATE_1_2;
            cnt    <= '0;
            phase  <= '0;
            hold   <= 1'b0;
            Out    <= 1'b0;
            Valid  <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state  <= state_n;
            len_q  <= len_n;
            rate_q <= rate_n;
            cnt    <= cnt_n;
            phase  <= phase_n;
            hold   <= hold_n;
            Out    <= out_n;
            Valid  <= valid_n;
            Done   <= done_n;
        end
    end

endmodule
